// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter that funnels NrPorts requesters (icache, dcache, ptw)
//   onto one downstream memory port with tagged, out-of-order responses.
//   A request is granted combinationally in the same cycle. If downstream
//   stalls, the grant and TID are locked until the handshake completes.
//   Responses are routed back to the port that owns the returned TID.
//
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   req_*                    per-port request channel (valid/ready/addr/we/wdata)
//   rsp_valid_o, rsp_data_o  per-port response pulse, shared response data
//   mem_req_*                downstream request channel carrying a TID
//   mem_rsp_*                downstream response (no backpressure)
//   outstanding_o            number of TIDs currently in flight
//   err_o                    pulse on a response whose TID is not allocated
module mem_port_arbiter #(
  parameter int unsigned NrPorts        = 3,
  parameter int unsigned MemTidWidth    = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NrPorts-1:0]                   req_valid_i,
  output logic [NrPorts-1:0]                   req_ready_o,
  input  logic [NrPorts*AddrWidth-1:0]         req_addr_i,
  input  logic [NrPorts-1:0]                   req_we_i,
  input  logic [NrPorts*DataWidth-1:0]         req_wdata_i,
  output logic [NrPorts-1:0]                   rsp_valid_o,
  output logic [DataWidth-1:0]                 rsp_data_o,
  output logic                                 mem_req_valid_o,
  input  logic                                 mem_req_ready_i,
  output logic [AddrWidth-1:0]                 mem_req_addr_o,
  output logic                                 mem_req_we_o,
  output logic [DataWidth-1:0]                 mem_req_wdata_o,
  output logic [MemTidWidth-1:0]               mem_req_tid_o,
  input  logic                                 mem_rsp_valid_i,
  input  logic [MemTidWidth-1:0]               mem_rsp_tid_i,
  input  logic [DataWidth-1:0]                 mem_rsp_data_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 err_o
);

  localparam int unsigned NumTids = 2 ** MemTidWidth;
  localparam int unsigned PortW   = (NrPorts > 1) ? $clog2(NrPorts) : 1;
  localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e                 state_r;
  logic [PortW-1:0]       lock_port_r;
  logic [MemTidWidth-1:0] lock_tid_r;
  logic [PortW-1:0]       rr_ptr_r;
  logic [NumTids-1:0]     busy_r;
  logic [PortW-1:0]       owner_r [NumTids];
  logic [CntW-1:0]        count_r;
  logic                   active_r;

  logic                   en_s;
  logic                   free_found_s;
  logic [MemTidWidth-1:0] free_tid_s;
  logic                   pick_found_s;
  logic [PortW-1:0]       pick_port_s;
  logic                   grant_valid_s;
  logic [PortW-1:0]       grant_port_s;
  logic [MemTidWidth-1:0] grant_tid_s;
  logic                   hs_s;
  logic                   rsp_hit_s;
  logic                   rsp_err_s;

  // active_r is low for the first cycle after reset, so outputs stay quiet
  // both during reset and in that cycle.
  assign en_s = rst_ni && active_r;

  // Lowest-numbered free TID.
  always_comb begin
    free_found_s = 1'b0;
    free_tid_s   = '0;
    for (int t = 0; t < NumTids; t++) begin
      if (!free_found_s && !busy_r[t]) begin
        free_found_s = 1'b1;
        free_tid_s   = MemTidWidth'(t);
      end else begin
        free_found_s = free_found_s;
      end
    end
  end

  // First valid port searching upward from rr_ptr_r, wrapping at NrPorts.
  always_comb begin
    int unsigned idx;
    idx          = 0;
    pick_found_s = 1'b0;
    pick_port_s  = '0;
    for (int i = 0; i < NrPorts; i++) begin
      idx = (32'(rr_ptr_r) + 32'(i)) % NrPorts;
      if (!pick_found_s && req_valid_i[idx]) begin
        pick_found_s = 1'b1;
        pick_port_s  = PortW'(idx);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Grant selection: a locked grant overrides arbitration; in IDLE a slot
  // must exist both in the count limit and in the TID table.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_port_s  = '0;
    grant_tid_s   = '0;
    if (state_r == LOCKED) begin
      grant_valid_s = en_s;
      grant_port_s  = lock_port_r;
      grant_tid_s   = lock_tid_r;
    end else begin
      grant_valid_s = en_s && pick_found_s && free_found_s &&
                      (count_r < CntW'(MaxOutstanding));
      grant_port_s  = pick_port_s;
      grant_tid_s   = free_tid_s;
    end
  end

  assign hs_s      = grant_valid_s && mem_req_ready_i;
  assign rsp_hit_s = en_s && mem_rsp_valid_i && busy_r[mem_rsp_tid_i];
  assign rsp_err_s = en_s && mem_rsp_valid_i && !busy_r[mem_rsp_tid_i];

  // Output steering for the request and response paths.
  always_comb begin
    req_ready_o     = '0;
    mem_req_valid_o = grant_valid_s;
    mem_req_addr_o  = '0;
    mem_req_we_o    = 1'b0;
    mem_req_wdata_o = '0;
    mem_req_tid_o   = '0;
    rsp_valid_o     = '0;
    rsp_data_o      = '0;
    err_o           = rsp_err_s;
    outstanding_o   = en_s ? count_r : '0;
    if (grant_valid_s) begin
      req_ready_o[grant_port_s] = mem_req_ready_i;
      mem_req_addr_o  = req_addr_i[grant_port_s*AddrWidth +: AddrWidth];
      mem_req_we_o    = req_we_i[grant_port_s];
      mem_req_wdata_o = req_wdata_i[grant_port_s*DataWidth +: DataWidth];
      mem_req_tid_o   = grant_tid_s;
    end else begin
      mem_req_tid_o = '0;
    end
    if (rsp_hit_s) begin
      rsp_valid_o[owner_r[mem_rsp_tid_i]] = 1'b1;
      rsp_data_o = mem_rsp_data_i;
    end else begin
      rsp_data_o = '0;
    end
  end

  // Grant FSM, TID table, outstanding counter and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      lock_port_r <= '0;
      lock_tid_r  <= '0;
      rr_ptr_r    <= '0;
      busy_r      <= '0;
      count_r     <= '0;
      active_r    <= 1'b0;
      for (int t = 0; t < NumTids; t++) begin
        owner_r[t] <= '0;
      end
    end else begin
      active_r <= 1'b1;
      // Free first, then allocate: the two TIDs can never collide because
      // a granted TID is always free and a hit TID is always busy.
      if (rsp_hit_s) begin
        busy_r[mem_rsp_tid_i] <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
      if (hs_s) begin
        busy_r[grant_tid_s]  <= 1'b1;
        owner_r[grant_tid_s] <= grant_port_s;
        rr_ptr_r <= (grant_port_s == PortW'(NrPorts - 1)) ? '0
                                                          : grant_port_s + PortW'(1);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      // Saturating count; simultaneous alloc and free cancel out.
      if (hs_s && !rsp_hit_s) begin
        if (count_r < CntW'(MaxOutstanding)) begin
          count_r <= count_r + CntW'(1);
        end else begin
          count_r <= count_r;
        end
      end else if (!hs_s && rsp_hit_s) begin
        if (count_r != '0) begin
          count_r <= count_r - CntW'(1);
        end else begin
          count_r <= count_r;
        end
      end else begin
        count_r <= count_r;
      end
      case (state_r)
        IDLE: begin
          if (grant_valid_s && !mem_req_ready_i) begin
            state_r     <= LOCKED;
            lock_port_r <= grant_port_s;
            lock_tid_r  <= grant_tid_s;
          end else begin
            state_r <= IDLE;
          end
        end
        LOCKED: begin
          if (hs_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= LOCKED;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- NrPorts, 3, number of requesters (0=icache, 1=dcache, 2=ptw).
- MemTidWidth, 2, transaction-ID width.
- MaxOutstanding, 4, outstanding-request limit; SHALL satisfy 1 <= MaxOutstanding <= 2**MemTidWidth.
- AddrWidth, 64, address width.
- DataWidth, 64, data width.
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- clk_i, in, 1, clock.
- rst_ni, in, 1, reset, synchronous and active-low.
- req_valid_i, in, NrPorts, per-port request valid.
- req_ready_o, out, NrPorts, per-port request accepted.
- req_addr_i, in, NrPorts*AddrWidth, per-port address.
- req_we_i, in, NrPorts, per-port write enable.
- req_wdata_i, in, NrPorts*DataWidth, per-port write data.
- rsp_valid_o, out, NrPorts, per-port response pulse.
- rsp_data_o, out, DataWidth, response data, shared by all ports.
- mem_req_valid_o, out, 1, downstream request valid.
- mem_req_ready_i, in, 1, downstream ready.
- mem_req_addr_o, out, AddrWidth, downstream address.
- mem_req_we_o, out, 1, downstream write enable.
- mem_req_wdata_o, out, DataWidth, downstream write data.
- mem_req_tid_o, out, MemTidWidth, downstream transaction ID.
- mem_rsp_valid_i, in, 1, downstream response valid; no backpressure.
- mem_rsp_tid_i, in, MemTidWidth, response transaction ID.
- mem_rsp_data_i, in, DataWidth, response data.
- outstanding_o, out, clog2(MaxOutstanding+1), live outstanding count.
- err_o, out, 1, one-cycle pulse on a response with an unallocated TID.

Function
REQ-003 The block SHALL hold state in two modes: IDLE (no grant locked) and LOCKED (grant register holds a port index and TID).
REQ-004 In IDLE, when a slot is available, the block SHALL grant combinationally, with zero-cycle latency, to the first valid port found searching from rr_ptr upward modulo NrPorts.
REQ-005 A slot SHALL be available only when outstanding count < MaxOutstanding and at least one TID is free.
REQ-006 The block SHALL assign the lowest-numbered free TID.
REQ-007 When no slot is available, mem_req_valid_o SHALL be 0 and every bit of req_ready_o SHALL be 0.
REQ-008 mem_req_valid_o, addr, we, wdata and tid SHALL be driven from the granted port and the allocated TID.
REQ-009 req_ready_o[g] SHALL equal mem_req_valid_o && mem_req_ready_i, where g is the granted port; all other bits SHALL be 0.
REQ-010 If mem_req_valid_o is high and mem_req_ready_i is low, the block SHALL enter LOCKED and keep the port and TID fixed until the handshake completes.
REQ-011 The block SHALL NOT re-arbitrate while LOCKED, even if a higher-priority port raises valid.
REQ-012 Requesters SHALL hold their request stable until ready; the block SHALL NOT check this.
REQ-013 On handshake the block SHALL, in the next cycle: mark the TID busy, record owner[tid]=g, increment the count, set rr_ptr=(g+1) mod NrPorts, and return to IDLE.
REQ-014 A handshake in IDLE SHALL leave the state in IDLE.
REQ-015 On mem_rsp_valid_i with a busy TID, rsp_valid_o[owner] SHALL pulse in the same cycle, with rsp_data_o=mem_rsp_data_i.
REQ-016 On that response the TID SHALL be freed and the count decremented in the next cycle; the freed TID SHALL NOT be reallocated in the same cycle it is freed.
REQ-017 On mem_rsp_valid_i with a free TID, the block SHALL pulse err_o and assert no rsp_valid_o bit; state SHALL be unchanged.
REQ-018 A handshake and a valid response in the same cycle SHALL leave the count unchanged, with the TID table updated for both events.
REQ-019 The count SHALL never exceed MaxOutstanding nor wrap below 0.
REQ-020 Every request, read or write, SHALL receive exactly one response.

Reset
REQ-021 While rst_ni=0 at a clk_i edge, the block SHALL clear: state=IDLE, rr_ptr=0, all TIDs free, count=0.
REQ-022 Every output SHALL be 0 in reset and in the first cycle after it.
REQ-023 Reset in LOCKED or with transactions outstanding SHALL abandon them; responses for those TIDs arriving after reset SHALL produce err_o.

Verification
REQ-024 Ports 0 and 2 valid, ready=1, rr_ptr=0 -> cycle 1 grant port 0 with tid0; cycle 2 grant port 2 with tid1; rr_ptr=0 after.
REQ-025 Port 1 valid, ready=0 for 3 cycles, port 0 raised in cycle 2 -> port 1 and tid0 held stable for all 3 cycles; port 0 granted after the handshake.
REQ-026 MaxOutstanding=4 and 4 requests issued with no responses -> outstanding_o=4, mem_req_valid_o=0; one response for tid2 -> next cycle a new request gets tid2.
REQ-027 Handshake and a response for tid0 in the same cycle, count=2 -> count stays 2, correct rsp_valid_o bit pulses.
REQ-028 Response with tid3 while tid3 is free -> err_o=1 for one cycle, rsp_valid_o=0, count unchanged.
REQ-029 rst_ni=0 in LOCKED with count=3 -> next cycle all outputs 0, count=0, rr_ptr=0.
